lbp_hist: RTL and testbench
===========================

Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage.
- Takes the LBP write stream (lbp_valid/lbp_data) and builds a 256-bin histogram of LBP codes for one frame.
- After the LBP stage raises finish, streams the 256 bin counts out over a valid/ready interface.
- Sits between the LBP core and the feature/result memory writer.

Parameters:
CNT_W, 16, width of each bin counter and of the pixel counter (must hold 126*126 = 15876).
NBINS, 256, number of bins; fixed by the 8-bit LBP code and not to be overridden.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
lbp_valid  input  1  one LBP code present this cycle
lbp_data  input  8  LBP code (bin index)
lbp_finish  input  1  level from LBP stage; high once the frame is complete
hist_ready  input  1  downstream accepts the current dump beat
clear  input  1  single-cycle request to zero the histogram and re-arm; honoured in DONE only
hist_valid  output  1  dump beat valid
hist_bin  output  8  bin index of current beat
hist_count  output  CNT_W  count for hist_bin
hist_done  output  1  high in DONE
pix_cnt  output  CNT_W  codes accumulated this frame (saturating)
overrun  output  1  sticky; lbp_valid seen outside ACCUM

Behaviour:
- Reset:
  - Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
  - On reset: all bins = 0, pix_cnt = 0, overrun = 0, dump pointer = 0.
  - Outputs after reset: hist_valid = 0, hist_bin = 0, hist_count = 0, hist_done = 0. State = ACCUM.
  - Reset mid-operation (any state) has the same effect. Any partial histogram is discarded.
- States: ACCUM, DUMP, DONE.
- ACCUM:
  - On each cycle with lbp_valid = 1: bin[lbp_data] increments by 1 and pix_cnt increments by 1, both visible the next cycle.
  - Back-to-back valid cycles are supported at one code per clock, including repeated codes. The increment is a single-cycle read-modify-write on a register array, so no hazard exists.
  - Bins and pix_cnt saturate at 2^CNT_W - 1 and never wrap.
  - lbp_finish = 1 sampled → DUMP next cycle.
  - If lbp_valid and lbp_finish are high in the same cycle, that code is still counted.
- DUMP:
  - hist_valid = 1 from the first DUMP cycle.
  - hist_bin = dump pointer; hist_count = bin[pointer], both combinational from the pointer.
  - A beat transfers when hist_valid && hist_ready. On transfer the pointer increments.
  - When hist_ready = 0, hist_bin and hist_count hold stable.
  - After the transfer of bin 255 → DONE. hist_valid = 0 from that next cycle. The pointer wraps to 0.
  - Exactly 256 beats are produced, in order 0..255.
  - lbp_valid in DUMP or DONE is ignored for counting and sets overrun = 1.
- DONE:
  - hist_done = 1, hist_valid = 0; bins and pix_cnt hold.
  - clear = 1 → all bins = 0, pix_cnt = 0, overrun = 0, state = ACCUM next cycle. hist_done is low from that cycle.
  - clear is ignored in ACCUM and DUMP.
  - lbp_finish still high in DONE has no effect; a return to DUMP requires clear followed by a new finish.
- Latency:
  - lbp_finish sampled at edge N → hist_valid high after edge N.
  - Minimum dump duration is 256 cycles with hist_ready held at 1.

Test Plan:
- Reset check: assert reset for 2 cycles with lbp_valid = 1, lbp_data = 0x12 → all outputs 0. After a dump, bin 0x12 = 0.
- Small frame: codes 5, 5, 200 back-to-back, then lbp_finish = 1, hist_ready = 1.
  - Required: 256 beats in order.
  - Bin 5 = 2, bin 200 = 1, all other bins 0.
  - pix_cnt = 3; hist_done = 1 one cycle after the beat for bin 255.
- Backpressure: same frame with hist_ready toggling 1,0,0,1 pseudo-randomly.
  - Required: hist_bin/hist_count stable while ready = 0.
  - No bin skipped or duplicated; total of 256 transfers.
- Full frame: 15876 codes of 0xFF, then finish → bin 255 = 15876, others 0, pix_cnt = 15876.
- Saturation with CNT_W = 4: 17 codes of 0x03 → bin 3 = 15, pix_cnt = 15.
- Overrun and clear:
  - lbp_valid = 1 (code 0x07) during DUMP → overrun = 1 and bin 7 is unchanged in the dump.
  - clear in DONE → overrun = 0, state ACCUM; the next frame's dump shows only that frame's codes.

Source files
------------

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for one frame,
// streamed out bin by bin over valid/ready after finish.
module lbp_hist #(
  parameter int CNT_W = 16,
  parameter int NBINS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [7:0]       lbp_data,
  input  logic             lbp_finish,
  input  logic             hist_ready,
  input  logic             clear,
  output logic             hist_valid,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ACCUM,
    DUMP,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bins_q [NBINS];
  logic [CNT_W-1:0] bins_d [NBINS];
  logic [7:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pix_d   = pix_q;
    ovr_d   = ovr_q;
    for (int i = 0; i < NBINS; i++) begin
      bins_d[i] = bins_q[i];
    end

    // Codes arriving outside accumulation are dropped but flagged.
    if (lbp_valid && state_q != ACCUM) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      ACCUM: begin
        if (lbp_valid) begin
          if (bins_q[lbp_data] != CNT_MAX) begin
            bins_d[lbp_data] = bins_q[lbp_data] + CNT_ONE;
          end
          if (pix_q != CNT_MAX) begin
            pix_d = pix_q + CNT_ONE;
          end
        end
        if (lbp_finish) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        if (hist_ready) begin
          ptr_d = ptr_q + 8'd1;
          if (ptr_q == 8'hFF) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (clear) begin
          for (int i = 0; i < NBINS; i++) begin
            bins_d[i] = '0;
          end
          pix_d   = '0;
          ovr_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      ptr_q   <= '0;
      pix_q   <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NBINS; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pix_q   <= pix_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < NBINS; i++) begin
        bins_q[i] <= bins_d[i];
      end
    end
  end

  assign hist_valid = (state_q == DUMP);
  assign hist_done  = (state_q == DONE);
  assign hist_bin   = ptr_q;
  assign hist_count = (state_q == DUMP) ? bins_q[ptr_q] : '0;
  assign pix_cnt    = pix_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: scoreboard bench for lbp_hist, plus a
// narrow-counter instance for saturation.
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid, lbp_finish, hist_ready, clear;
  logic [7:0]  lbp_data;
  logic        hist_valid, hist_done, overrun;
  logic [7:0]  hist_bin;
  logic [15:0] hist_count, pix_cnt;

  logic        s_valid, s_finish, s_ready, s_clear;
  logic [7:0]  s_data;
  logic        s_hv, s_done, s_ovr;
  logic [7:0]  s_bin;
  logic [3:0]  s_cnt, s_pix;

  int n_chk = 0;
  int n_fail = 0;
  int unsigned mbin [256];
  int unsigned mpix;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  lbp_hist #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .lbp_valid(lbp_valid), .lbp_data(lbp_data),
    .lbp_finish(lbp_finish), .hist_ready(hist_ready),
    .clear(clear), .hist_valid(hist_valid),
    .hist_bin(hist_bin), .hist_count(hist_count),
    .hist_done(hist_done), .pix_cnt(pix_cnt),
    .overrun(overrun)
  );

  lbp_hist #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .lbp_valid(s_valid), .lbp_data(s_data),
    .lbp_finish(s_finish), .hist_ready(s_ready),
    .clear(s_clear), .hist_valid(s_hv),
    .hist_bin(s_bin), .hist_count(s_cnt),
    .hist_done(s_done), .pix_cnt(s_pix),
    .overrun(s_ovr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mbin[i] = 0;
    mpix = 0;
  endtask

  task automatic feed(input logic [7:0] code);
    @(negedge clk);
    lbp_valid = 1'b1;
    lbp_data  = code;
    if (mbin[code] != 65535) mbin[code]++;
    if (mpix != 65535) mpix++;
  endtask

  task automatic dump(input bit bp, input bit inj);
    int beats = 0;
    int cyc = 0;
    bit stalled = 0;
    bit injected = 0;
    logic [7:0] pb;
    logic [15:0] pc;
    logic [31:0] e;
    bit r;
    @(negedge clk);
    lbp_valid = 1'b0;
    lbp_finish = 1'b1;
    for (int i = 0; i < 256; i++)
      exp_q.push_back({8'd0, 8'(i), 16'(mbin[i])});
    @(negedge clk);
    chk("latency_valid", 32'(hist_valid), 32'd1);
    chk("dump_done_low", 32'(hist_done), 32'd0);
    while (beats < 256 && cyc < 3000) begin
      cyc++;
      lbp_valid = 1'b0;
      if (hist_valid) begin
        if (stalled) begin
          chk("hold_bin", 32'(hist_bin), 32'(pb));
          chk("hold_cnt", 32'(hist_count), 32'(pc));
        end
        r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        hist_ready = r;
        if (r) begin
          if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_bin", 32'(hist_bin), 32'(e[23:16]));
            chk("beat_cnt", 32'(hist_count), 32'(e[15:0]));
          end
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          pb = hist_bin;
          pc = hist_count;
        end
        if (inj && beats == 10 && !injected) begin
          lbp_valid = 1'b1;
          lbp_data  = 8'h07;
          injected  = 1;
        end
      end
      @(negedge clk);
    end
    lbp_valid = 1'b0;
    hist_ready = 1'b0;
    if (beats < 256) chk("dump_timeout", 32'(beats), 32'd256);
    chk("valid_after", 32'(hist_valid), 32'd0);
    chk("done_after", 32'(hist_done), 32'd1);
    chk("pix_cnt", 32'(pix_cnt), 32'(mpix));
    chk("overrun", 32'(overrun), 32'(inj));
  endtask

  task automatic do_clear();
    @(negedge clk);
    lbp_finish = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_no_redump", 32'(hist_valid), 32'd0);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_done", 32'(hist_done), 32'd0);
    chk("clr_pix", 32'(pix_cnt), 32'd0);
    chk("clr_ovr", 32'(overrun), 32'd0);
    model_clear();
  endtask

  initial begin
    int beats;
    int cyc;
    reset = 1'b1;
    lbp_valid = 1'b1;
    lbp_data = 8'h12;
    lbp_finish = 1'b0;
    hist_ready = 1'b0;
    clear = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_finish = 1'b0;
    s_ready = 1'b1;
    s_clear = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(hist_valid), 32'd0);
    chk("rst_bin", 32'(hist_bin), 32'd0);
    chk("rst_cnt", 32'(hist_count), 32'd0);
    chk("rst_done", 32'(hist_done), 32'd0);
    chk("rst_pix", 32'(pix_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    lbp_valid = 1'b0;

    feed(8'd5); feed(8'd5); feed(8'd200);
    dump(1'b0, 1'b0);
    do_clear();

    feed(8'd5); feed(8'd5); feed(8'd200);
    dump(1'b1, 1'b1);
    do_clear();

    feed(8'd9); feed(8'd9); feed(8'd9); feed(8'd42);
    dump(1'b1, 1'b0);
    do_clear();

    for (int i = 0; i < 15876; i++) feed(8'hFF);
    dump(1'b0, 1'b0);
    do_clear();

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'h03;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_finish = 1'b1;
    @(negedge clk);
    beats = 0;
    cyc = 0;
    while (beats < 256 && cyc < 1000) begin
      cyc++;
      if (s_hv) begin
        chk("sat_bin", 32'(s_bin), 32'(beats));
        chk("sat_cnt", 32'(s_cnt),
            (beats == 3) ? 32'd15 : 32'd0);
        beats++;
      end
      @(negedge clk);
    end
    if (beats < 256) chk("sat_timeout", 32'(beats), 32'd256);
    chk("sat_pix", 32'(s_pix), 32'd15);
    chk("sat_done", 32'(s_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
